game_timer: RTL and testbench

Tick-driven countdown timer for a game round. It consumes the 1-cycle tick pulses from the shared enable-count prescaler and divides them down to seconds. It counts a two-digit BCD seconds value down to 00 and raises a timeout. It sits between the prescaler and the game control FSM / 7-segment display path.

---
 rtl/game_timer.sv | 163 ++++++++++++++++
 tb/tb_game_timer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_timer.sv
// game_timer: tick-driven two-digit BCD countdown with load, start/pause, warn and expiry.
// Optional time extension via `add` is compiled in only when GAME_TIMER_ADD_EN is defined.
module game_timer #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int WARN_SECS     = 5,
    parameter int ADD_SECS      = 10
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       load_i,
    input  logic [3:0] load_tens_i,
    input  logic [3:0] load_ones_i,
    input  logic       start_i,
    input  logic       pause_i,
    input  logic       add_i,
    output logic [3:0] sec_tens_o,
    output logic [3:0] sec_ones_o,
    output logic       running_o,
    output logic       expired_o,
    output logic       expire_pulse_o,
    output logic       warn_o
);

    localparam int            PW         = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [6:0]    WARN_LIMIT = 7'(WARN_SECS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        EXPIRED
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic          running_q;
    logic          expired_q;
    logic          pulse_q, pulse_d;

    logic          valueZero;
    logic          valueOne;
    logic          startGo;
    logic          pauseGo;
    logic          addGo;
    logic [3:0]    addTens;
    logic [3:0]    addOnes;
    logic [3:0]    clampTens;
    logic [3:0]    clampOnes;
    logic [6:0]    valueBin;

    assign valueZero = (tens_q == 4'd0) && (ones_q == 4'd0);
    assign valueOne  = (tens_q == 4'd0) && (ones_q == 4'd1);
    assign clampTens = (load_tens_i > 4'd9) ? 4'd9 : load_tens_i;
    assign clampOnes = (load_ones_i > 4'd9) ? 4'd9 : load_ones_i;

    // Simultaneous start and pause cancel each other out.
    assign startGo = start_i && !pause_i && ((state_q == IDLE) || (state_q == PAUSE)) && !valueZero;
    assign pauseGo = pause_i && !start_i && (state_q == RUN);

`ifdef GAME_TIMER_ADD_EN
    localparam logic [4:0] ADD_ONES = 5'(ADD_SECS % 10);
    localparam logic [4:0] ADD_TENS = 5'(ADD_SECS / 10);

    logic [4:0] onesSum;
    logic [4:0] tensSum;

    // Digit-wise BCD add with carry, saturating the whole value at 99.
    always_comb begin
        onesSum = {1'b0, ones_q} + ADD_ONES;
        tensSum = {1'b0, tens_q} + ADD_TENS;
        if (onesSum > 5'd9) begin
            onesSum = onesSum - 5'd10;
            tensSum = tensSum + 5'd1;
        end
        if (tensSum > 5'd9) begin
            addTens = 4'd9;
            addOnes = 4'd9;
        end else begin
            addTens = tensSum[3:0];
            addOnes = onesSum[3:0];
        end
    end

    assign addGo = add_i && (state_q != EXPIRED);
`else
    // Always false for legal ADD_SECS; keeps the port and parameter referenced.
    assign addGo   = add_i && (ADD_SECS > 99);
    assign addTens = tens_q;
    assign addOnes = ones_q;
`endif

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        pulse_d = 1'b0;
        if (load_i) begin
            tens_d  = clampTens;
            ones_d  = clampOnes;
            presc_d = '0;
            state_d = IDLE;
        end else if (addGo) begin
            tens_d = addTens;
            ones_d = addOnes;
        end else if (startGo) begin
            state_d = RUN;
        end else if (pauseGo) begin
            state_d = PAUSE;
        end else if (tick_i && (state_q == RUN)) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                if (ones_q == 4'd0) begin
                    ones_d = 4'd9;
                    tens_d = tens_q - 4'd1;
                end else begin
                    ones_d = ones_q - 4'd1;
                end
                if (valueOne) begin
                    state_d = EXPIRED;
                    pulse_d = 1'b1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Flags are registered from the next state so they line up with the digits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            running_q <= (state_d == RUN);
            expired_q <= (state_d == EXPIRED);
            pulse_q   <= pulse_d;
        end
    end

    assign valueBin = 7'({tens_q, 3'b000}) + 7'({tens_q, 1'b0}) + 7'(ones_q);

    assign sec_tens_o     = tens_q;
    assign sec_ones_o     = ones_q;
    assign running_o      = running_q;
    assign expired_o      = expired_q;
    assign expire_pulse_o = pulse_q;
    assign warn_o         = running_q && !valueZero && (valueBin <= WARN_LIMIT);

endmodule

// File: tb/tb_game_timer.sv
// tb_game_timer: directed plus randomized checks of game_timer against an integer-seconds model.
// Expected add behaviour follows whether GAME_TIMER_ADD_EN is defined for the build.
module tb_game_timer;

    localparam int TPS  = 4;
    localparam int WARN = 5;
    localparam int ADDS = 10;
`ifdef GAME_TIMER_ADD_EN
    localparam bit ADD_EN = 1'b1;
`else
    localparam bit ADD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       load = 1'b0;
    logic [3:0] loadTens = 4'd0;
    logic [3:0] loadOnes = 4'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       add = 1'b0;
    logic [3:0] secTens;
    logic [3:0] secOnes;
    logic       running;
    logic       expired;
    logic       expirePulse;
    logic       warn;

    int checks = 0;
    int failures = 0;
    int pulses = 0;

    // Reference model: whole seconds as an integer plus a tick counter.
    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_EXP} mstate_t;
    mstate_t mState = M_IDLE;
    int      mVal = 0;
    int      mPresc = 0;
    bit      mPulse = 1'b0;

    always #5 clk = ~clk;

    game_timer #(
        .TICKS_PER_SEC(TPS),
        .WARN_SECS    (WARN),
        .ADD_SECS     (ADDS)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .tick_i        (tick),
        .load_i        (load),
        .load_tens_i   (loadTens),
        .load_ones_i   (loadOnes),
        .start_i       (start),
        .pause_i       (pause),
        .add_i         (add),
        .sec_tens_o    (secTens),
        .sec_ones_o    (secOnes),
        .running_o     (running),
        .expired_o     (expired),
        .expire_pulse_o(expirePulse),
        .warn_o        (warn)
    );

    task automatic modelStep();
        int lt;
        int lo;
        mPulse = 1'b0;
        lt = (int'(loadTens) > 9) ? 9 : int'(loadTens);
        lo = (int'(loadOnes) > 9) ? 9 : int'(loadOnes);
        if (rst) begin
            mVal = 0;
            mPresc = 0;
            mState = M_IDLE;
        end else if (load) begin
            mVal = lt * 10 + lo;
            mPresc = 0;
            mState = M_IDLE;
        end else if (ADD_EN && add && mState != M_EXP) begin
            mVal = (mVal + ADDS > 99) ? 99 : mVal + ADDS;
        end else if (start && !pause && (mState == M_IDLE || mState == M_PAUSE) && mVal != 0) begin
            mState = M_RUN;
        end else if (pause && !start && mState == M_RUN) begin
            mState = M_PAUSE;
        end else if (tick && mState == M_RUN) begin
            mPresc = mPresc + 1;
            if (mPresc == TPS) begin
                mPresc = 0;
                mVal = mVal - 1;
                if (mVal == 0) begin
                    mState = M_EXP;
                    mPulse = 1'b1;
                end
            end
        end
    endtask

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string step);
        cmp({step, ".tens"}, 8'(secTens), 8'(mVal / 10));
        cmp({step, ".ones"}, 8'(secOnes), 8'(mVal % 10));
        cmp({step, ".running"}, 8'(running), 8'(mState == M_RUN));
        cmp({step, ".expired"}, 8'(expired), 8'(mState == M_EXP));
        cmp({step, ".pulse"}, 8'(expirePulse), 8'(mPulse));
        cmp({step, ".warn"}, 8'(warn), 8'(mState == M_RUN && mVal >= 1 && mVal <= WARN));
    endtask

    task automatic applyStimulus(input string step, input bit r, input bit t, input bit l,
                                 input bit s, input bit p, input bit a,
                                 input logic [3:0] lt, input logic [3:0] lo);
        rst = r;
        tick = t;
        load = l;
        start = s;
        pause = p;
        add = a;
        loadTens = lt;
        loadOnes = lo;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput(step);
        pulses += int'(expirePulse);
    endtask

    task automatic doIdle(input string step);
        applyStimulus(step, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0);
    endtask

    task automatic doTicks(input string step, input int n);
        for (int i = 0; i < n; i++) applyStimulus(step, 0, 1, 0, 0, 0, 0, 4'd0, 4'd0);
    endtask

    task automatic doLoad(input string step, input logic [3:0] lt, input logic [3:0] lo);
        applyStimulus(step, 0, 0, 1, 0, 0, 0, lt, lo);
    endtask

    task automatic doStart(input string step);
        applyStimulus(step, 0, 0, 0, 1, 0, 0, 4'd0, 4'd0);
    endtask

    initial begin
        // Reset with random noise on every other input.
        for (int i = 0; i < 2; i++)
            applyStimulus("reset", 1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), 4'($urandom), 4'($urandom));
        cmp("resetTens", 8'(secTens), 8'd0);
        cmp("resetOnes", 8'(secOnes), 8'd0);
        cmp("resetRunning", 8'(running), 8'd0);
        doTicks("postResetTick", 5);
        cmp("postResetValue", {secTens, secOnes}, 8'h00);

        doLoad("basicLoad", 4'd0, 4'd3);
        doStart("basicStart");
        pulses = 0;
        doTicks("basicTick", 4);
        cmp("basicAfter4", {secTens, secOnes}, 8'h02);
        doTicks("basicTick", 4);
        cmp("basicAfter8", {secTens, secOnes}, 8'h01);
        doTicks("basicTick", 3);
        cmp("basicPulseEarly", 8'(pulses), 8'd0);
        doTicks("basicTick", 1);
        cmp("basicAfter12", {secTens, secOnes}, 8'h00);
        cmp("basicPulseNow", 8'(expirePulse), 8'd1);
        doIdle("basicHold");
        cmp("basicPulseOnce", 8'(pulses), 8'd1);
        cmp("basicExpired", 8'(expired), 8'd1);
        doStart("basicRestart");
        cmp("basicRestartIgnored", 8'(running), 8'd0);

        doLoad("borrowLoad", 4'd1, 4'd0);
        doStart("borrowStart");
        doTicks("borrowTick", 4);
        cmp("borrow09", {secTens, secOnes}, 8'h09);
        cmp("borrowWarnLow", 8'(warn), 8'd0);
        doTicks("borrowTick", 16);
        cmp("borrow05", {secTens, secOnes}, 8'h05);
        cmp("borrowWarnHigh", 8'(warn), 8'd1);

        doLoad("pauseLoad", 4'd0, 4'd9);
        doStart("pauseStart");
        doTicks("pauseTick", 2);
        applyStimulus("pausePause", 0, 0, 0, 0, 1, 0, 4'd0, 4'd0);
        doTicks("pausedTick", 10);
        cmp("pauseFrozen", {secTens, secOnes}, 8'h09);
        doStart("pauseResume");
        doTicks("resumeTick", 2);
        cmp("resumeOneDec", {secTens, secOnes}, 8'h08);
        applyStimulus("startPauseBoth", 0, 0, 0, 1, 1, 0, 4'd0, 4'd0);
        cmp("startPauseStillRun", 8'(running), 8'd1);

        doLoad("clampLoad", 4'd1, 4'hA);
        cmp("clampValue", {secTens, secOnes}, 8'h19);
        doLoad("clampBoth", 4'hF, 4'hC);
        cmp("clampValue99", {secTens, secOnes}, 8'h99);
        doLoad("overLoad", 4'd0, 4'd1);
        doStart("overStart");
        doTicks("overTick", 3);
        pulses = 0;
        applyStimulus("overFinal", 0, 1, 1, 0, 0, 0, 4'd0, 4'd7);
        doIdle("overHold");
        cmp("overValue", {secTens, secOnes}, 8'h07);
        cmp("overNoPulse", 8'(pulses), 8'd0);
        doLoad("zeroLoad", 4'd0, 4'd0);
        doStart("zeroStart");
        cmp("zeroStaysIdle", 8'(running), 8'd0);

        doLoad("addLoad", 4'd9, 4'd5);
        applyStimulus("addPulse", 0, 0, 0, 0, 0, 1, 4'd0, 4'd0);
        cmp("addValue", {secTens, secOnes}, ADD_EN ? 8'h99 : 8'h95);
        doLoad("addExpLoad", 4'd0, 4'd1);
        doStart("addExpStart");
        doTicks("addExpTick", 4);
        applyStimulus("addInExpired", 0, 0, 0, 0, 0, 1, 4'd0, 4'd0);
        cmp("addExpiredValue", {secTens, secOnes}, 8'h00);

        // Randomized traffic with mostly small loads so expiry happens often.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] lt;
            logic [3:0] lo;
            lt = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
            lo = 4'($urandom_range(0, 15));
            applyStimulus("random",
                          $urandom_range(0, 199) == 0,
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 59) == 0,
                          $urandom_range(0, 7) == 0,
                          $urandom_range(0, 15) == 0,
                          $urandom_range(0, 39) == 0,
                          lt, lo);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
